ws2812b_pixel_fifo: RTL and testbench
=====================================

WS2812B_PIXEL_FIFO -- requirements
Module: ws2812b_pixel_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the pixel entry count and SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset; asynchronous assert, active-high.
REQ-004 byte_wr  input  1  one-cycle strobe; byte_data is valid.
REQ-005 byte_data  input  8  colour byte, in G, R, B order per pixel.
REQ-006 pixel_latch  input  1  sampled with the third byte of a pixel; marks the last pixel of a frame.
REQ-007 flush  input  1  synchronous clear of FIFO and byte assembler.
REQ-008 clear_ovf  input  1  clears the overflow flag.
REQ-009 out_ready  input  1  downstream LED driver can accept a pixel.
REQ-010 out_valid  output  1  head pixel is available.
REQ-011 out_data  output  24  head pixel, {G,R,B}.
REQ-012 out_latch  output  1  head pixel ends a frame.
REQ-013 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 level  output  5  current entry count, 0..FIFO_DEPTH.
REQ-015 byte_idx  output  2  bytes assembled for the pending pixel, 0..2.
REQ-016 overflow  output  1  sticky; a pixel was dropped.

Function
REQ-017 Byte assembly: byte_wr with byte_idx=0 SHALL load bits 23:16, with 1 bits 15:8, with 2 bits 7:0; byte_idx SHALL increment and wrap 2->0.
REQ-018 On the byte_idx=2 write, the pixel {assembled bits 23:8, byte_data} SHALL be pushed together with pixel_latch, unless the push is refused.
REQ-019 A push SHALL be refused when full=1 at the start of that cycle, including cycles with a simultaneous pop.
  - On refusal: the pixel is dropped, overflow is set, and byte_idx still wraps to 0.
REQ-020 out_valid SHALL equal (level!=0); out_data and out_latch SHALL present the head entry combinationally from the storage.
REQ-021 A pop SHALL occur only when out_valid and out_ready are both 1 in the same cycle.
REQ-022 A push accepted at edge N SHALL make the pixel visible on the outputs after edge N when the FIFO was empty (one cycle latency).
REQ-023 Simultaneous accepted push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 flush SHALL take priority over push, pop and byte_wr: level=0, pointers=0, byte_idx=0. overflow SHALL be unchanged by flush.
REQ-025 clear_ovf SHALL clear overflow; if a refused push occurs in the same cycle, overflow SHALL be set.
REQ-026 Storage contents SHALL NOT be reset and SHALL NOT be observable while out_valid=0.

Reset
REQ-027 While rst=1: level=0, pointers=0, byte_idx=0, overflow=0, out_valid=0, full=0.
REQ-028 Reset asserted mid-pixel or mid-frame SHALL discard all partial and queued pixels; the first byte after release SHALL be treated as G.

Configuration
REQ-029 Macro WS2812B_PIXEL_REPEAT_EN SHALL control the pixel-repeat feature.
REQ-030 With the macro defined:
  - Input repeat_cnt[7:0] is added and is sampled with the third byte into the entry.
  - The head entry SHALL be presented for repeat_cnt+1 handshakes before it is popped.
  - out_latch SHALL be 1 only on the final repetition.
  - An internal repetition counter SHALL be cleared by reset and flush.
REQ-031 Without the macro: no repeat_cnt port and no repetition counter; each entry is popped after a single handshake.

Verification
REQ-032 Write bytes 0x12,0x34,0x56 with pixel_latch=1 and out_ready=0 -> next cycle out_valid=1, out_data=0x123456, out_latch=1, level=1.
REQ-033 FIFO_DEPTH=4, out_ready=0, write 5 pixels -> full=1 after the 4th, 5th dropped, overflow=1, level=4, byte_idx=0.
REQ-034 Full FIFO; 3rd byte written in the same cycle as a pop -> pixel refused, level=3, overflow=1; clear_ovf -> overflow=0.
REQ-035 Two bytes written, then flush -> byte_idx=0, level=0; next bytes 0xAA,0xBB,0xCC -> out_data=0xAABBCC.
REQ-036 With WS2812B_PIXEL_REPEAT_EN defined and repeat_cnt=2 -> three handshakes of the same data, out_latch=1 only on the third, then level decrements.
REQ-037 Assert rst between the 1st and 2nd byte of a pixel -> all outputs at reset values; following 3 bytes form a correct pixel.

Source files
------------

// File: rtl/ws2812b_pixel_fifo.sv
// ws2812b_pixel_fifo: assembles G,R,B colour bytes into 24-bit pixels and
// queues them, with a frame-end marker, for a WS2812B LED driver.
// Optional feature macro: WS2812B_PIXEL_REPEAT_EN adds a repeat_cnt input.
// The head pixel is then presented for repeat_cnt+1 handshakes before it is popped.
module ws2812b_pixel_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_wr,
    input  logic [7:0]  byte_data,
    input  logic        pixel_latch,
    input  logic        flush,
    input  logic        clear_ovf,
    input  logic        out_ready,
`ifdef WS2812B_PIXEL_REPEAT_EN
    input  logic [7:0]  repeat_cnt,
`endif
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        out_latch,
    output logic        full,
    output logic [4:0]  level,
    output logic [1:0]  byte_idx,
    output logic        overflow
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       level_q, level_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      asm_q, asm_d;

    // Pixel storage; deliberately never reset, only gated on the outputs.
    logic [23:0]      mem_data  [FIFO_DEPTH];
    logic             mem_latch [FIFO_DEPTH];

    logic             push_req;
    logic             push_acc;
    logic             push_ref;
    logic             handshake;
    logic             pop;
    logic             last_rep;
    logic [23:0]      push_data;

`ifdef WS2812B_PIXEL_REPEAT_EN
    logic [7:0]       mem_rep [FIFO_DEPTH];
    logic [7:0]       rep_q, rep_d;
`endif

    assign full      = (level_q == DEPTH_L);
    assign out_valid = (level_q != 5'd0);
    assign level     = level_q;
    assign byte_idx  = byte_idx_q;
    assign overflow  = overflow_q;
    assign push_data = {asm_q, byte_data};

    // Handshake decode; flush overrides every push, pop and byte write.
    // Refusal looks only at full at the start of the cycle, so a concurrent pop
    // cannot make room for the incoming pixel.
    always_comb begin
        push_req  = byte_wr && (byte_idx_q == 2'd2) && !flush;
        push_acc  = push_req && !full;
        push_ref  = push_req && full;
        handshake = out_valid && out_ready && !flush;
`ifdef WS2812B_PIXEL_REPEAT_EN
        last_rep  = (rep_q == mem_rep[rd_ptr_q]);
`else
        last_rep  = 1'b1;
`endif
        pop       = handshake && last_rep;
    end

    // Head entry is visible only while the queue holds something.
    always_comb begin
        out_data  = 24'd0;
        out_latch = 1'b0;
        if (out_valid) begin
            out_data  = mem_data[rd_ptr_q];
            out_latch = mem_latch[rd_ptr_q] && last_rep;
        end
    end

    // Next-state for pointers, level, byte index and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        byte_idx_d = byte_idx_q;
        overflow_d = overflow_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (push_ref) begin
            overflow_d = 1'b1;
        end
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = 5'd0;
            byte_idx_d = 2'd0;
        end else begin
            if (byte_wr) begin
                byte_idx_d = (byte_idx_q >= 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
            end
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop) begin
                level_d = level_q + 5'd1;
            end else if (pop && !push_acc) begin
                level_d = level_q - 5'd1;
            end
        end
    end

    // Partial-pixel assembly of the G and R bytes.
    always_comb begin
        asm_d = asm_q;
        if (byte_wr && !flush) begin
            if (byte_idx_q == 2'd0) begin
                asm_d[15:8] = byte_data;
            end else if (byte_idx_q == 2'd1) begin
                asm_d[7:0] = byte_data;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            byte_idx_q <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            byte_idx_q <= byte_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath registers: assembler bytes and storage, no reset needed.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
        if (push_acc) begin
            mem_data[wr_ptr_q]  <= push_data;
            mem_latch[wr_ptr_q] <= pixel_latch;
`ifdef WS2812B_PIXEL_REPEAT_EN
            mem_rep[wr_ptr_q]   <= repeat_cnt;
`endif
        end
    end

`ifdef WS2812B_PIXEL_REPEAT_EN
    // Repetition counter; counts handshakes on the current head entry.
    always_comb begin
        rep_d = rep_q;
        if (flush) begin
            rep_d = 8'd0;
        end else if (handshake) begin
            rep_d = last_rep ? 8'd0 : rep_q + 8'd1;
        end
    end

    // Repetition counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= 8'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812b_pixel_fifo.sv
// Scoreboard bench for ws2812b_pixel_fifo (FIFO_DEPTH=4).
module tb_ws2812b_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_wr;
    logic [7:0]  byte_data;
    logic        pixel_latch;
    logic        flush;
    logic        clear_ovf;
    logic        out_ready;
`ifdef WS2812B_PIXEL_REPEAT_EN
    logic [7:0]  repeat_cnt;
`endif
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_latch;
    logic        full;
    logic [4:0]  level;
    logic [1:0]  byte_idx;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [24:0] sb_q[$];

    always #5 clk = ~clk;

    ws2812b_pixel_fifo #(.FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .byte_wr(byte_wr),
        .byte_data(byte_data),
        .pixel_latch(pixel_latch),
        .flush(flush),
        .clear_ovf(clear_ovf),
        .out_ready(out_ready),
`ifdef WS2812B_PIXEL_REPEAT_EN
        .repeat_cnt(repeat_cnt),
`endif
        .out_valid(out_valid),
        .out_data(out_data),
        .out_latch(out_latch),
        .full(full),
        .level(level),
        .byte_idx(byte_idx),
        .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wbyte(input logic [7:0] b, input logic l);
        byte_wr     = 1'b1;
        byte_data   = b;
        pixel_latch = l;
        cyc();
        byte_wr     = 1'b0;
        pixel_latch = 1'b0;
    endtask

    // Write a whole pixel; sb=1 means the bench expects it to come out.
    task automatic wpix(input logic [23:0] px, input logic l, input logic sb);
        wbyte(px[23:16], 1'b0);
        wbyte(px[15:8], 1'b0);
        wbyte(px[7:0], l);
        if (sb) sb_q.push_back({px, l});
    endtask

    // Monitor: every handshake seen before a rising edge pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pixel", {7'd0, out_data, out_latch}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_pixel_latch", {7'd0, out_data, out_latch}, {7'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; byte_wr = 1'b0; byte_data = 8'h00; pixel_latch = 1'b0;
        flush = 1'b0; clear_ovf = 1'b0; out_ready = 1'b0;
`ifdef WS2812B_PIXEL_REPEAT_EN
        repeat_cnt = 8'd0;
`endif
        cyc(); cyc();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        cyc();

        // Basic pixel: 12 34 56 with latch
        wbyte(8'h12, 1'b0);
        chk("idx_after_g", 32'(byte_idx), 32'd1);
        wbyte(8'h34, 1'b0);
        chk("idx_after_r", 32'(byte_idx), 32'd2);
        wbyte(8'h56, 1'b1);
        sb_q.push_back({24'h123456, 1'b1});
        chk("p1_valid", 32'(out_valid), 32'd1);
        chk("p1_data", 32'(out_data), 32'h123456);
        chk("p1_latch", 32'(out_latch), 32'd1);
        chk("p1_level", 32'(level), 32'd1);
        chk("p1_idx", 32'(byte_idx), 32'd0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("p1_drained", 32'(level), 32'd0);
        chk("p1_valid_low", 32'(out_valid), 32'd0);

        // Fill to full, fifth pixel dropped
        wpix(24'h010203, 1'b0, 1'b1);
        wpix(24'h040506, 1'b0, 1'b1);
        wpix(24'h070809, 1'b0, 1'b1);
        chk("fill3_full", 32'(full), 32'd0);
        wpix(24'h0A0B0C, 1'b1, 1'b1);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_level", 32'(level), 32'd4);
        chk("fill4_ovf", 32'(overflow), 32'd0);
        wpix(24'h0D0E0F, 1'b0, 1'b0);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_level", 32'(level), 32'd4);
        chk("drop_idx", 32'(byte_idx), 32'd0);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Full: third byte together with a pop is still refused
        wbyte(8'h11, 1'b0);
        wbyte(8'h12, 1'b0);
        out_ready = 1'b1;
        wbyte(8'h13, 1'b0);
        out_ready = 1'b0;
        chk("popfull_level", 32'(level), 32'd3);
        chk("popfull_ovf", 32'(overflow), 32'd1);
        chk("popfull_full", 32'(full), 32'd0);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        chk("clr_ovf2", 32'(overflow), 32'd0);
        wpix(24'h212223, 1'b0, 1'b1);
        chk("refill_full", 32'(full), 32'd1);
        // Refused push wins over clear_ovf in the same cycle
        wbyte(8'h31, 1'b0);
        wbyte(8'h32, 1'b0);
        clear_ovf = 1'b1;
        wbyte(8'h33, 1'b0);
        clear_ovf = 1'b0;
        chk("ovf_beats_clear", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (4) cyc();
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 32'd0);

        // Flush mid-pixel with a queued entry; overflow kept
        wpix(24'h414243, 1'b0, 1'b0);
        wbyte(8'h99, 1'b0);
        wbyte(8'h98, 1'b0);
        chk("preflush_idx", 32'(byte_idx), 32'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_idx", 32'(byte_idx), 32'd0);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ovf_kept", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        wpix(24'hAABBCC, 1'b0, 1'b1);
        chk("postflush_data", 32'(out_data), 32'hAABBCC);
        // Simultaneous push and pop keeps level
        wbyte(8'hDD, 1'b0);
        wbyte(8'hEE, 1'b0);
        out_ready = 1'b1;
        wbyte(8'hFF, 1'b1);
        sb_q.push_back({24'hDDEEFF, 1'b1});
        out_ready = 1'b0;
        chk("pushpop_level", 32'(level), 32'd1);
        chk("pushpop_data", 32'(out_data), 32'hDDEEFF);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Asynchronous reset between first and second byte
        wpix(24'h515253, 1'b0, 1'b0);
        clear_ovf = 1'b0;
        wbyte(8'h55, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_idx", 32'(byte_idx), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        cyc();
        rst = 1'b0;
        wpix(24'h5A6B7C, 1'b1, 1'b1);
        chk("postrst_data", 32'(out_data), 32'h5A6B7C);
        chk("postrst_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

`ifdef WS2812B_PIXEL_REPEAT_EN
        // Repeat head entry three times, latch only on the last
        repeat_cnt = 8'd2;
        wpix(24'h102030, 1'b1, 1'b0);
        repeat_cnt = 8'd0;
        sb_q.push_back({24'h102030, 1'b0});
        sb_q.push_back({24'h102030, 1'b0});
        sb_q.push_back({24'h102030, 1'b1});
        out_ready = 1'b1;
        cyc();
        chk("rep1_level", 32'(level), 32'd1);
        cyc();
        chk("rep2_level", 32'(level), 32'd1);
        cyc();
        chk("rep3_level", 32'(level), 32'd0);
        out_ready = 1'b0;
`endif

        cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
